iob_eth_tx: RTL and testbench

IOB_ETH_TX -- requirements
Module: iob_eth_tx

---
 rtl/iob_eth_tx_pkg.sv | 38 +++
 rtl/iob_eth_crc.sv | 42 ++++
 rtl/iob_eth_tx.sv | 198 +++++++++++++++++++
 tb/tb_iob_eth_tx.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_eth_tx_pkg.sv
// Shared definitions for the MII Ethernet transmitter: frame constants
// (SFD, preamble nibble, length and gap defaults), the FSM state type and
// the byte-wise Ethernet CRC-32 step used by iob_eth_crc.
package iob_eth_tx_pkg;

    localparam logic [7:0]  ETH_SFD          = 8'hD5;
    localparam logic [3:0]  ETH_PREAMBLE_NIB = 4'h5;
    localparam int          ETH_MIN_LEN      = 60;
    localparam int          ETH_MAX_LEN      = 1514;
    localparam int          ETH_IFG_BYTES    = 12;

    localparam int          PRE_NIBBLES      = 16;
    localparam int          FCS_NIBBLES      = 8;

    // Reflected CRC-32 (IEEE 802.3), shifted LSB first.
    localparam logic [31:0] ETH_CRC_POLY     = 32'hEDB88320;
    localparam logic [31:0] ETH_CRC_INIT     = 32'hFFFFFFFF;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_DATA = 3'd2,
        ST_PAD  = 3'd3,
        ST_FCS  = 3'd4,
        ST_IFG  = 3'd5
    } tx_state_t;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                               input logic [7:0]  b);
        logic [31:0] c;
        c = crc ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ ETH_CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/iob_eth_crc.sv
// Byte-serial Ethernet CRC-32 accumulator.
//   clk      : clock
//   rst      : async active-high reset (register back to all ones)
//   start    : restart the accumulation (has priority over data_en)
//   data_in  : byte to fold into the CRC
//   data_en  : one pulse per byte
//   crc_out  : complemented register, i.e. the FCS value ready to send
//              (byte [7:0] goes on the wire first)
module iob_eth_crc
    import iob_eth_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  data_in,
    input  logic        data_en,
    output logic [31:0] crc_out
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (start) begin
            crc_d = ETH_CRC_INIT;
        end else if (data_en) begin
            crc_d = crc32_byte(crc_q, data_in);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q <= ETH_CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_out = ~crc_q;

endmodule

// File: rtl/iob_eth_tx.sv
// MII Ethernet frame transmitter. On an accepted send it emits preamble+SFD,
// nlen payload bytes read from a synchronous buffer, zero padding up to
// MIN_LEN, the 32-bit FCS, then holds the line quiet for the inter-frame gap.
//   TX_CLK  : clock (all logic on rising edge)
//   rst     : async active-high reset
//   send    : start request, honoured only while ready=1
//   nbytes  : payload length, captured with send (clamped to MAX_LEN)
//   ready   : idle and able to accept send
//   addr    : buffer read address
//   data    : buffer byte, valid one cycle after addr
//   TX_EN   : MII transmit enable
//   TX_DATA : MII transmit nibble
//
// state | meaning
// IDLE  | waiting for send, CRC held at its start value
// PRE   | 15 preamble nibbles then the SFD high nibble
// DATA  | payload bytes from the buffer, low nibble first
// PAD   | zero bytes until MIN_LEN bytes have gone out
// FCS   | 8 CRC nibbles
// IFG   | quiet gap; together with the IDLE cycle it spans 2*IFG_BYTES
module iob_eth_tx
    import iob_eth_tx_pkg::*;
#(
    parameter int MIN_LEN   = ETH_MIN_LEN,
    parameter int MAX_LEN   = ETH_MAX_LEN,
    parameter int IFG_BYTES = ETH_IFG_BYTES
) (
    input  logic        TX_CLK,
    input  logic        rst,
    input  logic        send,
    input  logic [10:0] nbytes,
    output logic        ready,
    output logic [10:0] addr,
    input  logic [7:0]  data,
    output logic        TX_EN,
    output logic [3:0]  TX_DATA
);

    localparam logic [10:0] MIN_LEN_W = 11'(MIN_LEN);
    localparam logic [10:0] MAX_LEN_W = 11'(MAX_LEN);
    localparam logic [10:0] PRE_LOAD  = 11'(PRE_NIBBLES - 1);
    localparam logic [10:0] FCS_LOAD  = 11'(FCS_NIBBLES - 1);
    // The single IDLE cycle between back-to-back frames is the last gap
    // cycle, so the IFG state itself lasts one cycle less than the gap.
    localparam logic [10:0] IFG_LOAD  = 11'(2 * IFG_BYTES - 2);

    tx_state_t   state_q, state_d;
    logic [10:0] nlen_q, nlen_d;
    logic [10:0] byte_cnt_q, byte_cnt_d;
    logic [10:0] nib_cnt_q, nib_cnt_d;
    logic        hi_q, hi_d;
    logic [10:0] addr_q, addr_d;
    logic [7:0]  byte_q, byte_d;

    logic        tx_en;
    logic [3:0]  tx_data;
    logic        crc_start;
    logic        crc_en;
    logic [7:0]  cur_byte;
    logic [31:0] crc_out;
    logic [10:0] nlen_last;
    logic [2:0]  fcs_idx;
    logic        last_byte;

    assign cur_byte  = (state_q == ST_DATA) ? data : 8'h00;
    assign nlen_last = nlen_q - 11'd1;
    // nib_cnt counts down 7..0 in FCS, so nibble index is its complement.
    assign fcs_idx   = ~nib_cnt_q[2:0];

    always_comb begin
        state_d    = state_q;
        nlen_d     = nlen_q;
        byte_cnt_d = byte_cnt_q;
        nib_cnt_d  = nib_cnt_q;
        hi_d       = hi_q;
        addr_d     = addr_q;
        byte_d     = byte_q;
        tx_en      = 1'b0;
        tx_data    = 4'h0;
        crc_start  = 1'b0;
        crc_en     = 1'b0;
        last_byte  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                crc_start  = 1'b1;
                addr_d     = 11'd0;
                byte_cnt_d = 11'd0;
                hi_d       = 1'b0;
                if (send) begin
                    nlen_d    = (nbytes > MAX_LEN_W) ? MAX_LEN_W : nbytes;
                    nib_cnt_d = PRE_LOAD;
                    state_d   = ST_PRE;
                end
            end

            ST_PRE: begin
                tx_en   = 1'b1;
                tx_data = (nib_cnt_q == 11'd0) ? ETH_SFD[7:4] : ETH_PREAMBLE_NIB;
                if (nib_cnt_q == 11'd0) begin
                    state_d = (nlen_q == 11'd0) ? ST_PAD : ST_DATA;
                end else begin
                    nib_cnt_d = nib_cnt_q - 11'd1;
                end
            end

            ST_DATA, ST_PAD: begin
                tx_en = 1'b1;
                if (!hi_q) begin
                    // Low nibble: capture the byte, feed the CRC once, and move
                    // addr on now so the next byte is read during the high nibble.
                    tx_data = cur_byte[3:0];
                    byte_d  = cur_byte;
                    crc_en  = 1'b1;
                    hi_d    = 1'b1;
                    if (state_q == ST_DATA && byte_cnt_q != nlen_last) begin
                        addr_d = byte_cnt_q + 11'd1;
                    end
                end else begin
                    tx_data    = byte_q[7:4];
                    hi_d       = 1'b0;
                    byte_cnt_d = byte_cnt_q + 11'd1;
                    last_byte  = (state_q == ST_DATA) ? (byte_cnt_q == nlen_last)
                                                      : (byte_cnt_q == MIN_LEN_W - 11'd1);
                    if (last_byte) begin
                        if (state_q == ST_DATA && nlen_q < MIN_LEN_W) begin
                            state_d = ST_PAD;
                        end else begin
                            state_d   = ST_FCS;
                            nib_cnt_d = FCS_LOAD;
                        end
                    end
                end
            end

            ST_FCS: begin
                tx_en   = 1'b1;
                tx_data = crc_out[{fcs_idx, 2'b00} +: 4];
                addr_d  = 11'd0;
                if (nib_cnt_q == 11'd0) begin
                    state_d   = ST_IFG;
                    nib_cnt_d = IFG_LOAD;
                end else begin
                    nib_cnt_d = nib_cnt_q - 11'd1;
                end
            end

            ST_IFG: begin
                if (nib_cnt_q == 11'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    nib_cnt_d = nib_cnt_q - 11'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge TX_CLK or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            nlen_q     <= 11'd0;
            byte_cnt_q <= 11'd0;
            nib_cnt_q  <= 11'd0;
            hi_q       <= 1'b0;
            addr_q     <= 11'd0;
            byte_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            nlen_q     <= nlen_d;
            byte_cnt_q <= byte_cnt_d;
            nib_cnt_q  <= nib_cnt_d;
            hi_q       <= hi_d;
            addr_q     <= addr_d;
            byte_q     <= byte_d;
        end
    end

    iob_eth_crc u_crc (
        .clk     (TX_CLK),
        .rst     (rst),
        .start   (crc_start),
        .data_in (cur_byte),
        .data_en (crc_en),
        .crc_out (crc_out)
    );

    // Outputs decode straight from the state register so an async reset
    // drops TX_EN and TX_DATA without waiting for a clock.
    assign ready   = (state_q == ST_IDLE);
    assign addr    = addr_q;
    assign TX_EN   = tx_en;
    assign TX_DATA = tx_data;

endmodule

// File: tb/tb_iob_eth_tx.sv
module tb_iob_eth_tx;

    logic        TX_CLK = 1'b0;
    logic        rst;
    logic        send;
    logic [10:0] nbytes;
    logic        ready;
    logic [10:0] addr;
    logic [7:0]  data;
    logic        TX_EN;
    logic [3:0]  TX_DATA;

    logic [7:0]  mem [0:2047];

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [10:0] nbytes;
        int          fill;
        int          exp_cycles;
        int          exp_nlen;
    } vec_t;

    vec_t vecs [7];

    iob_eth_tx dut (
        .TX_CLK  (TX_CLK),
        .rst     (rst),
        .send    (send),
        .nbytes  (nbytes),
        .ready   (ready),
        .addr    (addr),
        .data    (data),
        .TX_EN   (TX_EN),
        .TX_DATA (TX_DATA)
    );

    always #5 TX_CLK = ~TX_CLK;

    // synchronous payload buffer: one cycle read latency
    always @(posedge TX_CLK) data <= mem[addr];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] crc_bits(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        logic        fb;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ b[i];
            c  = c >> 1;
            if (fb) c = c ^ 32'hEDB88320;
        end
        return c;
    endfunction

    task automatic fill_mem(input int mode);
        for (int i = 0; i < 2048; i++) begin
            mem[i] = (mode == 0) ? 8'(i) : 8'($urandom);
        end
    endtask

    task automatic run_frame(input logic [10:0] nb, input int exp_nlen, input int exp_cycles,
                             input int poke, input string tag);
        logic [3:0]  nibs [$];
        int          n, guard, max_addr, rdy_hi, nexp, bad;
        logic        pre_ok;
        logic [7:0]  got_b, exp_b;
        logic [31:0] ref_c, res_c, got_fcs, exp_fcs;
        guard = 0;
        while (!ready && guard < 100) begin
            @(negedge TX_CLK);
            guard++;
        end
        check({tag, " ready_wait"}, 64'(ready), 64'd1);
        send   = 1'b1;
        nbytes = nb;
        @(negedge TX_CLK);
        send   = 1'b0;
        nbytes = nb ^ 11'h7FF;
        n = 0; max_addr = 0; rdy_hi = 0;
        while (TX_EN === 1'b1 && n < 4000) begin
            nibs.push_back(TX_DATA);
            if (int'(addr) > max_addr) max_addr = int'(addr);
            if (ready !== 1'b0) rdy_hi++;
            send   = (n == poke);
            nbytes = 11'd5;
            @(negedge TX_CLK);
            n++;
        end
        send = 1'b0;
        check({tag, " tx_en_cycles"}, 64'(n), 64'(exp_cycles));

        pre_ok = (nibs.size() >= 16);
        if (pre_ok) begin
            for (int i = 0; i < 15; i++) if (nibs[i] !== 4'h5) pre_ok = 1'b0;
            if (nibs[15] !== 4'hD) pre_ok = 1'b0;
        end
        check({tag, " preamble_ok"}, 64'(pre_ok), 64'd1);

        nexp  = (exp_nlen < 60) ? 60 : exp_nlen;
        ref_c = 32'hFFFFFFFF;
        bad   = 0;
        for (int i = 0; i < nexp; i++) begin
            exp_b = (i < exp_nlen) ? mem[i] : 8'h00;
            ref_c = crc_bits(ref_c, exp_b);
            if (16 + 2 * i + 1 < nibs.size()) got_b = {nibs[16 + 2 * i + 1], nibs[16 + 2 * i]};
            else got_b = 8'hxx;
            if (got_b !== exp_b) bad++;
        end
        check({tag, " bad_bytes"}, 64'(bad), 64'd0);

        got_fcs = 32'hxxxxxxxx;
        if (nibs.size() >= 16 + 2 * nexp + 8) begin
            for (int j = 0; j < 8; j++) got_fcs[4 * j +: 4] = nibs[16 + 2 * nexp + j];
        end
        exp_fcs = ~ref_c;
        check({tag, " fcs"}, 64'(got_fcs), 64'(exp_fcs));

        res_c = ref_c;
        for (int j = 0; j < 4; j++) res_c = crc_bits(res_c, got_fcs[8 * j +: 8]);
        check({tag, " crc_residue"}, 64'(res_c), 64'hDEBB20E3);

        check({tag, " max_addr"}, 64'(max_addr), 64'((exp_nlen == 0) ? 0 : exp_nlen - 1));
        check({tag, " ready_in_frame"}, 64'(rdy_hi), 64'd0);
    endtask

    initial begin
        int h1, l1, rdy_cnt, h2, n, cnt;

        vecs[0] = '{11'd64,   0, 152,  64};
        vecs[1] = '{11'd10,   1, 144,  10};
        vecs[2] = '{11'd0,    0, 144,   0};
        vecs[3] = '{11'd2047, 1, 3052, 1514};
        vecs[4] = '{11'd60,   1, 144,  60};
        vecs[5] = '{11'd61,   0, 146,  61};
        vecs[6] = '{11'd59,   1, 144,  59};

        rst    = 1'b1;
        send   = 1'b0;
        nbytes = 11'd0;
        fill_mem(0);
        repeat (3) @(negedge TX_CLK);
        check("reset ready", 64'(ready), 64'd1);
        check("reset tx_en", 64'(TX_EN), 64'd0);
        check("reset tx_data", 64'(TX_DATA), 64'd0);
        check("reset addr", 64'(addr), 64'd0);
        rst = 1'b0;
        @(negedge TX_CLK);
        check("post_reset ready", 64'(ready), 64'd1);

        for (int v = 0; v < 7; v++) begin
            fill_mem(vecs[v].fill);
            run_frame(vecs[v].nbytes, vecs[v].exp_nlen, vecs[v].exp_cycles, -1,
                      $sformatf("vec%0d", v));
        end

        // back-to-back frames with send held high
        guard_ready();
        send = 1'b1; nbytes = 11'd60;
        @(negedge TX_CLK);
        h1 = 0;
        while (TX_EN === 1'b1 && h1 < 400) begin h1++; @(negedge TX_CLK); end
        l1 = 0; rdy_cnt = 0;
        while (TX_EN !== 1'b1 && l1 < 400) begin
            if (ready === 1'b1) rdy_cnt++;
            l1++;
            @(negedge TX_CLK);
        end
        send = 1'b0;
        h2 = 0;
        while (TX_EN === 1'b1 && h2 < 400) begin h2++; @(negedge TX_CLK); end
        check("b2b frame1_len", 64'(h1), 64'd144);
        check("b2b gap_len", 64'(l1), 64'd24);
        check("b2b ready_cycles", 64'(rdy_cnt), 64'd1);
        check("b2b frame2_len", 64'(h2), 64'd144);

        // send pulsed during DATA, then during IFG
        fill_mem(1);
        run_frame(11'd20, 20, 144, 40, "poke_data");
        repeat (5) @(negedge TX_CLK);
        send = 1'b1; nbytes = 11'd5;
        @(negedge TX_CLK);
        send = 1'b0;
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            if (TX_EN === 1'b1) cnt++;
            @(negedge TX_CLK);
        end
        check("poke_ifg extra_tx_cycles", 64'(cnt), 64'd0);

        // reset at payload byte 20 of a 100-byte frame
        fill_mem(0);
        guard_ready();
        send = 1'b1; nbytes = 11'd100;
        @(negedge TX_CLK);
        send = 1'b0;
        n = 0;
        while (TX_EN === 1'b1 && n < 56) begin @(negedge TX_CLK); n++; end
        check("midrst reach_byte20", 64'(n), 64'd56);
        check("midrst addr_at_byte20", 64'(addr), 64'd20);
        rst = 1'b1;
        #1;
        check("midrst tx_en", 64'(TX_EN), 64'd0);
        check("midrst ready", 64'(ready), 64'd1);
        check("midrst tx_data", 64'(TX_DATA), 64'd0);
        check("midrst addr", 64'(addr), 64'd0);
        @(negedge TX_CLK);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge TX_CLK);
            if (TX_EN === 1'b1) cnt++;
        end
        check("midrst no_resume", 64'(cnt), 64'd0);
        fill_mem(1);
        run_frame(11'd60, 60, 144, -1, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    task automatic guard_ready();
        int g;
        g = 0;
        while (ready !== 1'b1 && g < 100) begin
            @(negedge TX_CLK);
            g++;
        end
        check("wait_ready", 64'(ready), 64'd1);
    endtask

endmodule
